// File: rtl/spi_pkg.sv
// Shared frame-state encoding and frame-layout constants for the SPI register bank.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } frame_state_e;

  // R/W is the first bit on the wire; a 1 there means write
  localparam int unsigned RW_BIT_POS = 0;
  localparam logic        RW_WRITE   = 1'b1;

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle: the controller drives SCLK/nCS/COPI, the register bank drives CIPO/cipo_oe.
interface spi_reg_bank_if;

  logic SCLK;
  logic nCS;
  logic COPI;
  logic CIPO;
  logic cipo_oe;

  modport master (output SCLK, output nCS, output COPI, input CIPO, input cipo_oe);
  modport slave  (input SCLK, input nCS, input COPI, output CIPO, output cipo_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall strobes
// derived from the synchronised level only.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: frames of R/W, address and data bits, MSB first,
// written into or read from NUM_REGS registers; everything runs on clk.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o,
  output logic                       frame_err_o
);

  localparam int unsigned      LAST_BIT     = ADDR_W + DATA_W;
  localparam int unsigned      CNT_W        = $clog2(LAST_BIT + 1);
  localparam int unsigned      RW_IDX       = ADDR_W - RW_BIT_POS;
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(LAST_BIT);

  logic sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s, copi_s;
  logic sclk_lvl_unused_s, ncs_lvl_unused_s, copi_rise_unused_s, copi_fall_unused_s;

  frame_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] hdr_q, addr_q;
  logic [DATA_W-1:0] dat_q, rd_q, wdata_s, snap_s;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic rw_q, in_range_q, frame_err_q, cipo_q, cipo_oe_q;

  logic [ADDR_W:0]   hdr_full_s;
  logic [ADDR_W-1:0] addr_s;
  logic rw_s, in_range_s;
  logic hdr_shift_s, hdr_done_s, dat_shift_s, dat_done_s, drive_s, abort_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(spi.SCLK),
    .sync_o(sclk_lvl_unused_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_i(spi.nCS),
    .sync_o(ncs_lvl_unused_s), .rise_o(ncs_rise_s), .fall_o(ncs_fall_s));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_i(spi.COPI),
    .sync_o(copi_s), .rise_o(copi_rise_unused_s), .fall_o(copi_fall_unused_s));

  // the bit arriving on this edge completes the header / data word
  assign hdr_full_s = {hdr_q, copi_s};
  assign rw_s       = hdr_full_s[RW_IDX];
  assign addr_s     = hdr_full_s[ADDR_W-1:0];
  assign in_range_s = (32'(addr_s) < NUM_REGS);
  assign wdata_s    = DATA_W'({dat_q, copi_s});
  assign hdr_done_s = hdr_shift_s && (cnt_q == CNT_HDR_LAST);
  assign dat_done_s = dat_shift_s && (cnt_q == CNT_LAST);

  // frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // frame state transitions; nCS rising always wins over an SCLK edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ncs_fall_s) state_d = ST_ADDR; else state_d = ST_IDLE;
      ST_ADDR: begin
        if (ncs_rise_s) state_d = ST_IDLE;
        else if (sclk_rise_s && (cnt_q == CNT_HDR_LAST)) state_d = ST_DATA;
        else state_d = ST_ADDR;
      end
      ST_DATA: begin
        if (ncs_rise_s) state_d = ST_IDLE;
        else if (sclk_rise_s && (cnt_q == CNT_LAST)) state_d = ST_DONE;
        else state_d = ST_DATA;
      end
      ST_DONE: if (ncs_rise_s) state_d = ST_IDLE; else state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // per-state datapath strobes
  always_comb begin
    hdr_shift_s = 1'b0;
    dat_shift_s = 1'b0;
    drive_s     = 1'b0;
    abort_s     = 1'b0;
    case (state_q)
      ST_ADDR: begin
        abort_s     = ncs_rise_s;
        hdr_shift_s = sclk_rise_s & ~ncs_rise_s;
      end
      ST_DATA: begin
        abort_s     = ncs_rise_s;
        dat_shift_s = sclk_rise_s & ~ncs_rise_s;
        drive_s     = sclk_fall_s & ~ncs_rise_s & (rw_q != RW_WRITE);
      end
      default: abort_s = 1'b0;
    endcase
  end

  // read mux; an out-of-range address matches nothing and reads as zero
  always_comb begin
    snap_s = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      snap_s = snap_s | ({DATA_W{32'(addr_s) == k}} & regs_q[k]);
    end
  end

  // bit counter, shift registers, register file and output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      hdr_q       <= '0;
      addr_q      <= '0;
      dat_q       <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      in_range_q  <= 1'b0;
      wr_pulse_q  <= '0;
      frame_err_q <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      wr_pulse_q  <= '0;
      frame_err_q <= 1'b0;
      if (state_d == ST_IDLE) cnt_q <= '0;
      else if (hdr_shift_s || (dat_shift_s && !dat_done_s)) cnt_q <= cnt_q + CNT_W'(1);
      if (hdr_shift_s) hdr_q <= hdr_full_s[ADDR_W-1:0];
      if (hdr_done_s) begin
        rw_q       <= rw_s;
        addr_q     <= addr_s;
        in_range_q <= in_range_s;
        rd_q       <= (rw_s == RW_WRITE) ? '0 : snap_s;
        cipo_oe_q  <= (rw_s != RW_WRITE);
      end
      if (dat_shift_s) dat_q <= wdata_s;
      if (drive_s) begin
        cipo_q <= rd_q[DATA_W-1];
        rd_q   <= rd_q << 1;
      end
      if (dat_done_s) begin
        cipo_oe_q <= 1'b0;
        cipo_q    <= 1'b0;
        if (!in_range_q) frame_err_q <= 1'b1;
        if (in_range_q && (rw_q == RW_WRITE)) begin
          for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(addr_q) == k) begin
              regs_q[k]     <= wdata_s;
              wr_pulse_q[k] <= 1'b1;
            end
          end
        end
      end
      if (abort_s) begin
        frame_err_q <= 1'b1;
        cipo_oe_q   <= 1'b0;
        cipo_q      <= 1'b0;
      end
    end
  end

  // flatten the register file onto the output bus
  always_comb begin
    regs_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) regs_o[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign wr_pulse_o  = wr_pulse_q;
  assign frame_err_o = frame_err_q;
  assign spi.CIPO    = cipo_q;
  assign spi.cipo_oe = cipo_oe_q;

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, number of writable/readable registers (1..128).
REQ-002 SHALL have parameter DATA_W, default 8, register and data-phase width in bits (1..32).
REQ-003 SHALL have parameter ADDR_W, default 7, address-phase width; frame length is 1+ADDR_W+DATA_W bits.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per SPI input (>=2).
REQ-005 SHALL have ports: clk  input  1  system clock, the only clock; all logic on its rising edge.
REQ-006 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: SCLK  input  1  SPI clock (mode 0), asynchronous to clk.
REQ-008 SHALL have ports: nCS  input  1  active-low chip select, asynchronous to clk.
REQ-009 SHALL have ports: COPI  input  1  controller-out data, MSB first.
REQ-010 SHALL have ports: CIPO  output  1  peripheral-out read data; 0 when not driving.
REQ-011 SHALL have ports: cipo_oe  output  1  high only during the data phase of a read frame.
REQ-012 SHALL have ports: regs_o  output  NUM_REGS*DATA_W  register contents, register k at bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have ports: wr_pulse_o  output  NUM_REGS  one-clk pulse on the register just written.
REQ-014 SHALL have ports: frame_err_o  output  1  one-clk pulse on aborted frame or out-of-range address.

Function
REQ-015 SCLK, nCS and COPI SHALL each pass SYNC_STAGES flops; edges SHALL be detected from the synchronised SCLK only.
REQ-016 SCLK high and low times SHALL be at least SYNC_STAGES+2 clk periods; faster SCLK is unsupported.
REQ-017 State machine SHALL have states IDLE, ADDR, DATA, DONE; IDLE->ADDR on synchronised nCS falling.
REQ-018 In ADDR, bit 0 of the frame SHALL be R/W (1 = write), then ADDR_W address bits, sampled on SCLK rising, MSB first.
REQ-019 ADDR->DATA after the last address bit; a bit counter SHALL count 0..ADDR_W+DATA_W and never wrap.
REQ-020 Write frame: after the final data bit, the addressed register and its wr_pulse_o bit SHALL update on the clk cycle after that SCLK rising edge is detected.
REQ-021 Read frame: at ADDR->DATA the addressed register SHALL be snapshotted; the MSB SHALL drive CIPO from the next SCLK falling edge, with subsequent bits shifted on each falling edge.
REQ-022 Read of an address >= NUM_REGS SHALL return all zeros and pulse frame_err_o at end of frame; write to it SHALL change nothing and pulse frame_err_o.
REQ-023 DATA->DONE after the final bit; in DONE further SCLK edges SHALL be ignored until nCS rises.
REQ-024 nCS rising in ADDR or DATA SHALL abort: no register write, frame_err_o pulsed, return to IDLE.
REQ-025 nCS rising in DONE or IDLE SHALL return to IDLE with no error.
REQ-026 A write to register k and a read snapshot of register k SHALL never occur in the same frame; back-to-back frames SHALL see prior writes.
REQ-027 cipo_oe and CIPO SHALL be 0 outside DATA of a read frame.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, regs_o all 0, wr_pulse_o 0, frame_err_o 0, CIPO 0, cipo_oe 0, synchronisers 0 (nCS synchronisers to 1).
REQ-029 Reset mid-frame SHALL discard the frame; the first frame after reset requires a fresh nCS falling edge.

Structure
REQ-030 Frame-state encoding and R/W bit-position constants SHALL live in a shared package spi_pkg.
REQ-031 The input synchroniser with edge detect SHALL be a sub-module spi_sync_edge, instantiated per input.

Verification
REQ-032 Write 0x80,0xA5 (addr 0, data 0xA5) -> regs_o[7:0]=0xA5, wr_pulse_o=5'b00001 for one clk.
REQ-033 Write addr 4 data 0x3C, then read addr 4 -> CIPO shifts 0x3C MSB first, cipo_oe high for 8 SCLK periods.
REQ-034 Write addr 0x05 (NUM_REGS=5) data 0xFF -> no regs_o change, frame_err_o one pulse.
REQ-035 nCS raised after 10 bits of a write to addr 1 -> regs_o unchanged, frame_err_o one pulse, next full frame succeeds.
REQ-036 20 SCLK pulses in one write frame to addr 2, data 0x11 -> only the first 16 bits used, regs_o[23:16]=0x11.
REQ-037 rst_n low mid-read -> all outputs 0 immediately; subsequent read of addr 0 returns 0x00.
